// File: rtl/spi_xfer_arbiter.sv
// Round-robin arbiter sharing one SPI master core among NREQ requesters.
// Ports:
//   pclk, preset             clock, synchronous active-high reset
//   req/req_data/req_mode    per-requester request level, tx byte, spimode
//   grant, done, err         one-hot owner, completion pulse, timeout flag
//   rd_data, busy            last received byte, non-idle indicator
//   mstr, spiswai            core status; gate new grants only
//   senddata/spimode/tx_data start pulse and transfer setup to the core
//   tip/receivedata/rx_data  progress and result from the core
module spi_xfer_arbiter #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned DW       = 8,
  parameter int unsigned START_TO = 64,
  parameter int unsigned GAP      = 2
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ*2-1:0] req_mode,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic              err,
  output logic [DW-1:0]     rd_data,
  output logic              busy,
  input  logic              mstr,
  input  logic              spiswai,
  output logic              senddata,
  output logic [1:0]        spimode,
  output logic [DW-1:0]     tx_data,
  input  logic              tip,
  input  logic              receivedata,
  input  logic [DW-1:0]     rx_data
);

  localparam int unsigned PW = $clog2(NREQ);
  localparam int unsigned TW = $clog2(START_TO + 1);
  localparam int unsigned GW = $clog2(GAP + 1);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_LAUNCH   = 3'd1;
  localparam logic [2:0] ST_WAIT_TIP = 3'd2;
  localparam logic [2:0] ST_XFER     = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;
  localparam logic [2:0] ST_GAP      = 3'd5;

  logic [2:0]      state_q, state_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [GW-1:0]   gcnt_q, gcnt_d;

  logic [NREQ-1:0] grant_d, done_d;
  logic            err_d, busy_d, senddata_d;
  logic [DW-1:0]   rd_data_d, tx_data_d;
  logic [1:0]      spimode_d;

  logic            win_found;
  logic [PW-1:0]   win_idx;
  logic [PW-1:0]   cidx;
  logic [NREQ-1:0] win_onehot;
  logic [DW-1:0]   win_data;
  logic [1:0]      win_mode;

  // State and registered outputs
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      ptr_q    <= '0;
      tcnt_q   <= '0;
      gcnt_q   <= '0;
      grant    <= '0;
      done     <= '0;
      err      <= 1'b0;
      rd_data  <= '0;
      busy     <= 1'b0;
      senddata <= 1'b0;
      spimode  <= 2'b00;
      tx_data  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      tcnt_q   <= tcnt_d;
      gcnt_q   <= gcnt_d;
      grant    <= grant_d;
      done     <= done_d;
      err      <= err_d;
      rd_data  <= rd_data_d;
      busy     <= busy_d;
      senddata <= senddata_d;
      spimode  <= spimode_d;
      tx_data  <= tx_data_d;
    end
  end

  // Round-robin pick, next state and next output values
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    tcnt_d     = tcnt_q;
    gcnt_d     = gcnt_q;
    grant_d    = grant;
    done_d     = '0;
    err_d      = 1'b0;
    rd_data_d  = rd_data;
    senddata_d = 1'b0;
    spimode_d  = spimode;
    tx_data_d  = tx_data;
    win_found  = 1'b0;
    win_idx    = '0;
    cidx       = '0;
    win_onehot = '0;
    win_data   = '0;
    win_mode   = 2'b00;

    // First set request at or after ptr, wrapping modulo NREQ
    for (int i = 0; i < int'(NREQ); i++) begin
      cidx = PW'((int'(ptr_q) + i) % int'(NREQ));
      if (!win_found && req[cidx]) begin
        win_found = 1'b1;
        win_idx   = cidx;
      end
    end
    for (int i = 0; i < int'(NREQ); i++) begin
      if (win_idx == PW'(i)) begin
        win_onehot[i] = 1'b1;
        win_data      = req_data[i*DW +: DW];
        win_mode      = req_mode[i*2 +: 2];
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (win_found && mstr && !spiswai) begin
          state_d    = ST_LAUNCH;
          owner_d    = win_idx;
          grant_d    = win_onehot;
          tx_data_d  = win_data;
          spimode_d  = win_mode;
          senddata_d = 1'b1;
        end
      end
      ST_LAUNCH: begin
        tcnt_d  = '0;
        state_d = ST_WAIT_TIP;
      end
      ST_WAIT_TIP: begin
        // A fast core may finish without ever showing tip
        if (receivedata) begin
          rd_data_d = rx_data;
          done_d    = grant;
          state_d   = ST_DONE;
        end else if (tip) begin
          state_d = ST_XFER;
        end else if (tcnt_q == TW'(START_TO - 1)) begin
          done_d  = grant;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (tcnt_q != TW'(START_TO)) begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      ST_XFER: begin
        if (receivedata) begin
          rd_data_d = rx_data;
          done_d    = grant;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        ptr_d   = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + PW'(1);
        grant_d = '0;
        gcnt_d  = '0;
        state_d = ST_GAP;
      end
      ST_GAP: begin
        if (gcnt_q == GW'(GAP - 1)) begin
          state_d = ST_IDLE;
        end else begin
          gcnt_d = gcnt_q + GW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

endmodule
